// File: rtl/minmax_stream_avg.sv
// Frame-based min/max tracker: collects COUNT samples after a start pulse and
// reports average, range, min or max of the frame extremes with a done pulse.
module minmax_stream_avg #(
  parameter int DATA_W = 8,
  parameter int COUNT  = 8,
  parameter int SIGNED = 0,
  parameter int ROUND  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] W,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              done,
  output logic              busy
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int SW = DATA_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, CALC} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] result;
  logic [SW-1:0]     sum;

  function automatic logic lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] v);
    return {(SIGNED != 0) && v[DATA_W-1], v};
  endfunction

  // The extra sum bit absorbs the carry; dropping it after the shift makes
  // logical and arithmetic shifts equivalent here.
  always_comb begin
    sum    = ext(run_min) + ext(run_max) + SW'(ROUND != 0);
    result = '0;
    case (mode_q)
      2'b00:   result = DATA_W'(sum >> 1);
      2'b01:   result = run_max - run_min;
      2'b10:   result = run_min;
      default: result = run_max;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_q  <= '0;
      run_min <= '0;
      run_max <= '0;
      W       <= '0;
      min_out <= '0;
      max_out <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (data_valid) begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
              run_min <= data;
              run_max <= data;
            end else begin
              if (lt(data, run_min)) run_min <= data;
              if (lt(run_max, data)) run_max <= data;
            end
            if (cnt == CW'(COUNT - 1)) state <= CALC;
          end
        end
        CALC: begin
          W       <= result;
          min_out <= run_min;
          max_out <= run_max;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
